// File: rtl/ppc_types.sv
`default_nettype none
// ============================================================================
// Module : ppc_types
// Brief  : Shared types for the system-unit issue path (station select, order entry).
// Rev    : 1.0
// ============================================================================
package ppc_types;

    localparam int SYS_SRC_WIDTH   = 2;
    localparam int SYS_RS_ID_WIDTH = 5;

    typedef enum logic [SYS_SRC_WIDTH-1:0] {
        SYS_RS_GPR = 2'd0,
        SYS_RS_SPR = 2'd1,
        SYS_RS_CR  = 2'd2
    } sys_rs_sel_t;

    typedef struct packed {
        sys_rs_sel_t                src;
        logic [SYS_RS_ID_WIDTH-1:0] id;
    } sys_order_entry_t;

endpackage
`default_nettype wire

// File: rtl/order_fifo.sv
`default_nettype none
// ============================================================================
// Module : order_fifo
// Brief  : Synchronous FIFO with head peek; depth need not be a power of two.
// Rev    : 1.0
// ============================================================================
module order_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    // Storage is not reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_issue_sequencer.sv
`default_nettype none
// ============================================================================
// Module : sys_issue_sequencer
// Brief  : Program-order issue from GPR/SPR/CR stations into a registered sys_unit stage.
// Rev    : 1.0
// ============================================================================
module sys_issue_sequencer
    import ppc_types::*;
#(
    parameter int REQUESTERS  = 3,
    parameter int RS_ID_WIDTH = SYS_RS_ID_WIDTH,
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 16,
    parameter int ORDER_DEPTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_valid,
    input  logic [$clog2(REQUESTERS)-1:0]    alloc_src,
    input  logic [RS_ID_WIDTH-1:0]           alloc_id,
    output logic                             alloc_ready,
    input  logic [REQUESTERS-1:0]            req_valid,
    output logic [REQUESTERS-1:0]            req_ready,
    input  logic [RS_ID_WIDTH-1:0]           req_id      [0:REQUESTERS-1],
    input  logic [DATA_WIDTH-1:0]            req_op      [0:REQUESTERS-1],
    input  logic [CTRL_WIDTH-1:0]            req_control [0:REQUESTERS-1],
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RS_ID_WIDTH-1:0]           out_id,
    output logic [DATA_WIDTH-1:0]            out_op,
    output logic [CTRL_WIDTH-1:0]            out_control,
    output logic [$clog2(ORDER_DEPTH+1)-1:0] pending,
    output logic                             order_error
);

    localparam int ENTRY_W = $bits(sys_order_entry_t);

    sys_order_entry_t         w_push_entry;
    sys_order_entry_t         w_head;
    logic [ENTRY_W-1:0]       w_head_raw;
    logic [SYS_SRC_WIDTH-1:0] w_head_src;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_can_load;
    logic                     w_sel_valid;
    logic [RS_ID_WIDTH-1:0]   w_sel_id;
    logic [DATA_WIDTH-1:0]    w_sel_op;
    logic [CTRL_WIDTH-1:0]    w_sel_ctrl;
    logic                     w_id_match;
    logic                     w_grant;
    logic                     w_mismatch;

    logic                     r_out_valid;
    logic [RS_ID_WIDTH-1:0]   r_out_id;
    logic [DATA_WIDTH-1:0]    r_out_op;
    logic [CTRL_WIDTH-1:0]    r_out_ctrl;
    logic                     r_order_error;

    assign w_push_entry.src = sys_rs_sel_t'(SYS_SRC_WIDTH'(alloc_src));
    assign w_push_entry.id  = SYS_RS_ID_WIDTH'(alloc_id);

    order_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (alloc_valid & alloc_ready),
        .pop       (w_grant),
        .push_data (w_push_entry),
        .head      (w_head_raw),
        .count     (pending),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_head      = w_head_raw;
    assign w_head_src  = w_head.src;
    assign alloc_ready = ~w_full;
    assign w_can_load  = ~r_out_valid | out_ready;

    // Only the head station is ever looked at; an out-of-range src selects nothing.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
        w_sel_op    = '0;
        w_sel_ctrl  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (int'(w_head_src) == i) begin
                w_sel_valid = req_valid[i];
                w_sel_id    = req_id[i];
                w_sel_op    = req_op[i];
                w_sel_ctrl  = req_control[i];
            end
        end
    end

    assign w_id_match = (SYS_RS_ID_WIDTH'(w_sel_id) == w_head.id);
    assign w_grant    = ~w_empty & w_sel_valid & w_id_match & w_can_load;
    assign w_mismatch = ~w_empty & w_sel_valid & ~w_id_match;

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_req_ready
        assign req_ready[g] = w_grant & (int'(w_head_src) == g);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid   <= 1'b0;
            r_out_id      <= '0;
            r_out_op      <= '0;
            r_out_ctrl    <= '0;
            r_order_error <= 1'b0;
        end else begin
            if (w_grant) begin
                r_out_valid <= 1'b1;
                r_out_id    <= w_sel_id;
                r_out_op    <= w_sel_op;
                r_out_ctrl  <= w_sel_ctrl;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_mismatch) begin
                r_order_error <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_id      = r_out_id;
    assign out_op      = r_out_op;
    assign out_control = r_out_ctrl;
    assign order_error = r_order_error;

endmodule
`default_nettype wire
